// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy sprite controller.
package enemy_pkg;

    typedef enum logic [2:0] {
        MOVE_R,
        MOVE_L,
        DESC_R,
        DESC_L,
        LANDED,
        DYING,
        DEAD
    } enemy_state_t;

    // Default transparent colour key (magenta).
    localparam logic [23:0] KEY_COLOR_DEFAULT = 24'hFF00FF;

    // Debug box pixels are all-ones; replicated to the colour width by users.
    localparam logic DEBUG_BOX_FILL = 1'b1;

    // States in which the sprite is drawn unconditionally and a hit is honoured.
    function automatic logic is_active_state(enemy_state_t s);
        return s inside {MOVE_R, MOVE_L, DESC_R, DESC_L, LANDED};
    endfunction

endpackage

// File: rtl/enemy_sprite_ctrl_if.sv
// Raster, sprite-ROM and status signals of one enemy sprite controller.
interface enemy_sprite_ctrl_if #(
    parameter int unsigned ADDRESS    = 10,
    parameter int unsigned COLOR_BITS = 24,
    parameter int unsigned CNT_BITS   = 10
);
    logic                  frame_tick;
    logic [CNT_BITS-1:0]   hcount;
    logic [CNT_BITS-1:0]   vcount;
    logic                  active;
    logic                  hit;
    logic [ADDRESS-1:0]    rom_addr;
    logic [COLOR_BITS-1:0] rom_dout;
    logic [COLOR_BITS-1:0] pix_color;
    logic                  pix_valid;
    logic                  alive;
    logic                  landed;
    logic [CNT_BITS-1:0]   pos_x;
    logic [CNT_BITS-1:0]   pos_y;

    // Video timing / game logic / ROM side.
    modport master (
        output frame_tick, hcount, vcount, active, hit, rom_dout,
        input  rom_addr, pix_color, pix_valid, alive, landed, pos_x, pos_y
    );

    // Enemy controller side.
    modport slave (
        input  frame_tick, hcount, vcount, active, hit, rom_dout,
        output rom_addr, pix_color, pix_valid, alive, landed, pos_x, pos_y
    );
endinterface

// File: rtl/enemy_sprite_scan.sv
// Two-stage sprite scan: box test and ROM address, then registered colour/valid.
// Optional macro ENEMY_DEBUG_BOX_EN draws the sprite box perimeter in white.
module enemy_sprite_scan
    import enemy_pkg::*;
#(
    parameter int unsigned ADDRESS    = 10,
    parameter int unsigned COLOR_BITS = 24,
    parameter int unsigned SPRITE_W   = 32,
    parameter int unsigned SPRITE_H   = 32,
    parameter int unsigned CNT_BITS   = 10,
    parameter logic [COLOR_BITS-1:0] KEY_COLOR = COLOR_BITS'(KEY_COLOR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_BITS-1:0]   hcount,
    input  logic [CNT_BITS-1:0]   vcount,
    input  logic                  active,
    input  logic [CNT_BITS-1:0]   pos_x,
    input  logic [CNT_BITS-1:0]   pos_y,
    input  logic                  visible,
`ifdef ENEMY_DEBUG_BOX_EN
    input  logic                  dead,
`endif
    input  logic [COLOR_BITS-1:0] rom_dout,
    output logic [ADDRESS-1:0]    rom_addr,
    output logic [COLOR_BITS-1:0] pix_color,
    output logic                  pix_valid
);

    typedef logic [CNT_BITS:0] wide_t;

    wide_t               h_w, v_w, x_lo, x_hi, y_lo, y_hi;
    logic                inbox, inbox_q;
    logic [CNT_BITS-1:0] dx, dy;
    logic [ADDRESS-1:0]  addr_next;

    // One extra bit so the right/bottom box edge never wraps near the counter limit.
    assign h_w  = {1'b0, hcount};
    assign v_w  = {1'b0, vcount};
    assign x_lo = {1'b0, pos_x};
    assign y_lo = {1'b0, pos_y};
    assign x_hi = x_lo + wide_t'(SPRITE_W - 1);
    assign y_hi = y_lo + wide_t'(SPRITE_H - 1);

    assign inbox = active && (h_w >= x_lo) && (h_w <= x_hi) && (v_w >= y_lo) && (v_w <= y_hi);

    // Only the low ADDRESS bits matter, so the product is formed at that width.
    assign dx        = hcount - pos_x;
    assign dy        = vcount - pos_y;
    assign addr_next = ADDRESS'(dy) * ADDRESS'(SPRITE_W) + ADDRESS'(dx);

    // Stage 1: capture ROM address for in-box pixels; qualify with blink/visibility.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            inbox_q  <= 1'b0;
        end else begin
            if (inbox) begin
                rom_addr <= addr_next;
            end
            inbox_q <= inbox && visible;
        end
    end

`ifdef ENEMY_DEBUG_BOX_EN
    logic perim, perim_q;

    assign perim = inbox && !dead &&
                   ((h_w == x_lo) || (h_w == x_hi) || (v_w == y_lo) || (v_w == y_hi));

    // Stage 1 (debug): remember perimeter pixels alongside the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perim_q <= 1'b0;
        end else begin
            perim_q <= perim;
        end
    end

    // Stage 2: perimeter overrides ROM colour, key and blink.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_color <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_color <= perim_q ? {COLOR_BITS{DEBUG_BOX_FILL}} : rom_dout;
            pix_valid <= perim_q || (inbox_q && (rom_dout != KEY_COLOR));
        end
    end
`else
    // Stage 2: register ROM colour; keyed pixels are transparent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_color <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_color <= rom_dout;
            pix_valid <= inbox_q && (rom_dout != KEY_COLOR);
        end
    end
`endif

endmodule

// File: rtl/enemy_sprite_ctrl.sv
// One enemy: movement/death FSM stepped on frame ticks, plus the sprite scan pipeline.
// Optional macro ENEMY_DEBUG_BOX_EN enables the white box perimeter overlay.
module enemy_sprite_ctrl
    import enemy_pkg::*;
#(
    parameter int unsigned ADDRESS    = 10,
    parameter int unsigned COLOR_BITS = 24,
    parameter int unsigned SPRITE_W   = 32,
    parameter int unsigned SPRITE_H   = 32,
    parameter int unsigned CNT_BITS   = 10,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned FLOOR_Y    = 400,
    parameter int unsigned START_X    = 0,
    parameter int unsigned START_Y    = 40,
    parameter int unsigned STEP_X     = 2,
    parameter int unsigned STEP_Y     = 16,
    parameter int unsigned FRAME_DIV  = 2,
    parameter int unsigned DIE_FRAMES = 16,
    parameter logic [COLOR_BITS-1:0] KEY_COLOR = COLOR_BITS'(KEY_COLOR_DEFAULT)
) (
    input logic                clk,
    input logic                rst,
    enemy_sprite_ctrl_if.slave bus
);

    localparam int unsigned DIV_W = $clog2(FRAME_DIV + 1);
    localparam int unsigned DIE_W = $clog2(DIE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [DIE_W-1:0] DIE_LAST = DIE_W'(DIE_FRAMES - 1);

    typedef logic [CNT_BITS:0] wide_t;

    enemy_state_t        state_q, state_d;
    logic [CNT_BITS-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIE_W-1:0]    die_q, die_d;
    logic [CNT_BITS-1:0] y_down;
    logic                step, at_right, at_left, floor_hit, visible;

    assign y_down    = pos_y_q + CNT_BITS'(STEP_Y);
    assign at_right  = ({1'b0, pos_x_q} + wide_t'(SPRITE_W + STEP_X)) > wide_t'(SCREEN_W);
    assign at_left   = pos_x_q < CNT_BITS'(STEP_X);
    assign floor_hit = ({1'b0, y_down} + wide_t'(SPRITE_H)) >= wide_t'(FLOOR_Y);

    // State register; position only moves here on frame ticks, so no mid-frame tearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MOVE_R;
            pos_x_q <= CNT_BITS'(START_X);
            pos_y_q <= CNT_BITS'(START_Y);
            div_q   <= '0;
            die_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            div_q   <= div_d;
            die_q   <= die_d;
        end
    end

    // Next state: a hit pre-empts any step on the same cycle.
    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        div_d   = div_q;
        die_d   = die_q;
        step    = 1'b0;
        if (bus.hit && is_active_state(state_q)) begin
            state_d = DYING;
            die_d   = '0;
        end else if (bus.frame_tick) begin
            unique case (state_q)
                MOVE_R, MOVE_L, DESC_R, DESC_L: begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        step  = 1'b1;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                DYING: begin
                    if (die_q == DIE_LAST) begin
                        state_d = DEAD;
                    end else begin
                        die_d = die_q + DIE_W'(1);
                    end
                end
                default: ;
            endcase
            if (step) begin
                unique case (state_q)
                    MOVE_R: begin
                        if (at_right) state_d = DESC_R;
                        else          pos_x_d = pos_x_q + CNT_BITS'(STEP_X);
                    end
                    MOVE_L: begin
                        if (at_left) state_d = DESC_L;
                        else         pos_x_d = pos_x_q - CNT_BITS'(STEP_X);
                    end
                    DESC_R: begin
                        pos_y_d = y_down;
                        state_d = floor_hit ? LANDED : MOVE_L;
                    end
                    DESC_L: begin
                        pos_y_d = y_down;
                        state_d = floor_hit ? LANDED : MOVE_R;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Blink while dying: drawn on even die counts only.
    assign visible    = is_active_state(state_q) || ((state_q == DYING) && !die_q[0]);
    assign bus.alive  = (state_q != DEAD);
    assign bus.landed = (state_q == LANDED);
    assign bus.pos_x  = pos_x_q;
    assign bus.pos_y  = pos_y_q;

    enemy_sprite_scan #(
        .ADDRESS    (ADDRESS),
        .COLOR_BITS (COLOR_BITS),
        .SPRITE_W   (SPRITE_W),
        .SPRITE_H   (SPRITE_H),
        .CNT_BITS   (CNT_BITS),
        .KEY_COLOR  (KEY_COLOR)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .hcount    (bus.hcount),
        .vcount    (bus.vcount),
        .active    (bus.active),
        .pos_x     (pos_x_q),
        .pos_y     (pos_y_q),
        .visible   (visible),
`ifdef ENEMY_DEBUG_BOX_EN
        .dead      (state_q == DEAD),
`endif
        .rom_dout  (bus.rom_dout),
        .rom_addr  (bus.rom_addr),
        .pix_color (bus.pix_color),
        .pix_valid (bus.pix_valid)
    );

endmodule

// File: tb/tb_enemy_sprite_ctrl.sv
// Randomised bench for enemy_sprite_ctrl against a behavioural game/raster model.
module tb_enemy_sprite_ctrl;

    localparam int SW         = 32;
    localparam int SH         = 32;
    localparam int FRAME_DIV  = 2;
    localparam int DIE_FRAMES = 16;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic clk;
    logic rst;

    enemy_sprite_ctrl_if bus ();

    enemy_sprite_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM model: asynchronous read.
    function automatic logic [23:0] rom_f(input logic [9:0] a);
        if (a == 10'd0) return 24'h00FF00;
        if (a == 10'd161 || (a % 5) == 3) return KEY;
        return {a[7:0], ~a[7:0], a[9:2]};
    endfunction

    assign bus.rom_dout = rom_f(bus.rom_addr);

    int total, bad;

    // Behavioural model: enemy as position + direction + flags, pixels as a 2-deep history.
    int          m_x, m_y, m_dir, m_ticks, m_die_ticks, e_rom_addr;
    bit          m_pend, m_landed, m_dying, m_dead;
    bit          s1_inbox, e_pix_valid;
    logic [23:0] e_pix_color;
`ifdef ENEMY_DEBUG_BOX_EN
    bit          s1_perim;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 40; m_dir = 1; m_ticks = 0; m_die_ticks = 0;
        m_pend = 0; m_landed = 0; m_dying = 0; m_dead = 0;
        e_rom_addr = 0; e_pix_color = '0; e_pix_valid = 0; s1_inbox = 0;
`ifdef ENEMY_DEBUG_BOX_EN
        s1_perim = 0;
`endif
    endtask

    task automatic move_step();
        if (m_pend) begin
            m_y += 16;
            m_dir = -m_dir;
            m_pend = 0;
            if (m_y + SH >= 400) m_landed = 1;
        end else if (m_dir > 0) begin
            if (m_x + SW + 2 > 640) m_pend = 1;
            else m_x += 2;
        end else begin
            if (m_x < 2) m_pend = 1;
            else m_x -= 2;
        end
    endtask

    // Apply one rising edge to the model using the inputs held across it.
    task automatic model_advance();
        int hc, vc;
        bit inb, vis;
        logic [23:0] col;
        hc = int'(bus.hcount);
        vc = int'(bus.vcount);
        col = rom_f(10'(e_rom_addr));
        e_pix_color = col;
        e_pix_valid = s1_inbox && (col != KEY);
`ifdef ENEMY_DEBUG_BOX_EN
        if (s1_perim) begin
            e_pix_color = 24'hFFFFFF;
            e_pix_valid = 1;
        end
`endif
        inb = bus.active && hc >= m_x && hc <= m_x + SW - 1 && vc >= m_y && vc <= m_y + SH - 1;
        vis = !m_dead && (!m_dying || (m_die_ticks % 2) == 0);
        if (inb) e_rom_addr = ((vc - m_y) * SW + (hc - m_x)) % 1024;
        s1_inbox = inb && vis;
`ifdef ENEMY_DEBUG_BOX_EN
        s1_perim = inb && !m_dead &&
                   (hc == m_x || hc == m_x + SW - 1 || vc == m_y || vc == m_y + SH - 1);
`endif
        if (bus.hit && !m_dying && !m_dead) begin
            m_dying = 1;
            m_landed = 0;
            m_die_ticks = 0;
        end else if (bus.frame_tick) begin
            if (m_dying) begin
                m_die_ticks++;
                if (m_die_ticks == DIE_FRAMES) begin
                    m_dying = 0;
                    m_dead = 1;
                end
            end else if (!m_dead && !m_landed) begin
                m_ticks++;
                if (m_ticks % FRAME_DIV == 0) move_step();
            end
        end
    endtask

    task automatic check_all();
        chk("rom_addr", 32'(bus.rom_addr), 32'(e_rom_addr));
        chk("pix_color", 32'(bus.pix_color), 32'(e_pix_color));
        chk("pix_valid", 32'(bus.pix_valid), 32'(e_pix_valid));
        chk("alive", 32'(bus.alive), 32'(!m_dead));
        chk("landed", 32'(bus.landed), 32'(m_landed));
        chk("pos_x", 32'(bus.pos_x), 32'(m_x));
        chk("pos_y", 32'(bus.pos_y), 32'(m_y));
    endtask

    task automatic set_raster(input int h, input int v, input bit a);
        bus.hcount = 10'(h);
        bus.vcount = 10'(v);
        bus.active = a;
    endtask

    // Mostly aim near the sprite so the box edges get exercised.
    task automatic drive_rand();
        if ($urandom_range(0, 7) == 0)
            set_raster(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1);
        else
            set_raster(m_x + int'($urandom_range(0, 39)) - 4,
                       m_y + int'($urandom_range(0, 39)) - 4,
                       $urandom_range(0, 7) != 0);
    endtask

    task automatic step(input bit tick, input bit hit_in, input bit rnd);
        if (rnd) drive_rand();
        bus.frame_tick = tick;
        bus.hit = hit_in;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_advance();
        check_all();
        bus.frame_tick = 1'b0;
        bus.hit = 1'b0;
    endtask

    // Asynchronous reset asserted between edges, held over one edge, then released.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step(0, 0, 1);
        rst = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen_desc, seen_left;
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.frame_tick = 1'b0;
        bus.hit = 1'b0;
        set_raster(0, 0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("reset_pos_y", 32'(bus.pos_y), 32'd40);
        chk("reset_alive", 32'(bus.alive), 32'd1);
        rst = 1'b0;

        // First pixel and address arithmetic.
        set_raster(0, 40, 1'b1);
        step(0, 0, 0);
        chk("first_addr", 32'(bus.rom_addr), 32'd0);
        set_raster(1, 45, 1'b1);
        step(0, 0, 0);
`ifdef ENEMY_DEBUG_BOX_EN
        chk("first_color_box", 32'(bus.pix_color), 32'hFFFFFF);
`else
        chk("first_color", 32'(bus.pix_color), 32'h00FF00);
`endif
        chk("first_valid", 32'(bus.pix_valid), 32'd1);
        chk("addr_161", 32'(bus.rom_addr), 32'd161);
        set_raster(32, 45, 1'b1);
        step(0, 0, 0);
        chk("key_valid", 32'(bus.pix_valid), 32'd0);
        step(0, 0, 0);
        chk("outside_valid", 32'(bus.pix_valid), 32'd0);
        chk("addr_hold", 32'(bus.rom_addr), 32'd161);

        step(1, 0, 0);
        step(1, 0, 0);
        chk("two_ticks_x", 32'(bus.pos_x), 32'd2);

        // Sweep until landed.
        n = 0;
        seen_desc = 0;
        seen_left = 0;
        while (!m_landed && n < 40000) begin
            step($urandom_range(0, 3) != 0, 0, 1);
            n++;
            if (!seen_desc && m_y != 40) begin
                seen_desc = 1;
                chk("first_desc_y", 32'(bus.pos_y), 32'd56);
                chk("first_desc_x", 32'(bus.pos_x), 32'd608);
            end else if (seen_desc && !seen_left && m_x != 608) begin
                seen_left = 1;
                chk("first_left_x", 32'(bus.pos_x), 32'd606);
            end
        end
        chk("landed_flag", 32'(bus.landed), 32'd1);
        chk("landed_y", 32'(bus.pos_y), 32'd376);
        chk("landed_x", 32'(bus.pos_x), 32'd608);
        repeat (10) step(1, 0, 1);
        chk("landed_hold_y", 32'(bus.pos_y), 32'd376);
        chk("landed_hold_x", 32'(bus.pos_x), 32'd608);

        // Hit on a step tick at x=10, then blink and die.
        mid_reset();
        repeat (11) begin
            step(1, 0, 1);
            step(0, 0, 1);
        end
        step(1, 1, 1);
        chk("hit_x", 32'(bus.pos_x), 32'd10);
        chk("hit_alive", 32'(bus.alive), 32'd1);
        set_raster(12, 45, 1'b1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("blink_on", 32'(bus.pix_valid), 32'd1);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("blink_off", 32'(bus.pix_valid), 32'd0);
        repeat (DIE_FRAMES - 1) begin
            step(1, 0, 1);
            repeat ($urandom_range(1, 4)) step(0, 0, 1);
        end
        chk("dead_alive", 32'(bus.alive), 32'd0);
        set_raster(12, 45, 1'b1);
        repeat (3) step(0, 0, 0);
        chk("dead_valid", 32'(bus.pix_valid), 32'd0);
        step(0, 1, 1);
        step(0, 0, 1);
        chk("dead_hit_alive", 32'(bus.alive), 32'd0);

        // Reset mid-line while dying.
        mid_reset();
        step(0, 1, 1);
        repeat (3) begin
            step(1, 0, 1);
            step(0, 0, 1);
        end
        set_raster(12, 45, 1'b1);
        step(0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_pos_x", 32'(bus.pos_x), 32'd0);
        chk("rst_pos_y", 32'(bus.pos_y), 32'd40);
        chk("rst_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_color", 32'(bus.pix_color), 32'd0);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_alive", 32'(bus.alive), 32'd1);
        model_reset();
        check_all();
        step(0, 0, 1);
        rst = 1'b0;

`ifdef ENEMY_DEBUG_BOX_EN
        set_raster(0, 50, 1'b1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("box_color", 32'(bus.pix_color), 32'hFFFFFF);
        chk("box_valid", 32'(bus.pix_valid), 32'd1);
`else
        set_raster(0, 40, 1'b1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("post_rst_color", 32'(bus.pix_color), 32'h00FF00);
        chk("post_rst_valid", 32'(bus.pix_valid), 32'd1);
`endif

        // Free-running stretch with sparse hits.
        repeat (3000) step($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
